// File: rtl/butterfly_stage_feeder_6.sv
// Frame-buffered feeder for one radix-2 FFT stage: load a frame, run every butterfly pair in place, then stream the frame out.
// Optional macro FEEDER_SCALE_EN: halve each butterfly result (arithmetic shift right by 1) before write-back.
module butterfly_stage_feeder_6 #(
    parameter int DATA_W     = 12,
    parameter int N_POINTS   = 16,
    parameter int STAGE_SPAN = 8,
    parameter int BF_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_img,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_img,
    output logic              frame_done,
    output logic              busy,
    output logic [DATA_W-1:0] bf_x_m_real,
    output logic [DATA_W-1:0] bf_x_m_img,
    output logic [DATA_W-1:0] bf_x_n_real,
    output logic [DATA_W-1:0] bf_x_n_img,
    output logic [2:0]        bf_index,
    input  logic [DATA_W-1:0] bf_x_m_1_real,
    input  logic [DATA_W-1:0] bf_x_m_1_img,
    input  logic [DATA_W-1:0] bf_x_n_1_real,
    input  logic [DATA_W-1:0] bf_x_n_1_img
);
    localparam int AW      = $clog2(N_POINTS);
    localparam int PW      = (AW > 1) ? AW - 1 : 1;
    localparam int HW      = (BF_LATENCY > 0) ? $clog2(BF_LATENCY + 1) : 1;
    localparam int SPAN_LG = $clog2(STAGE_SPAN);
    localparam int TW_LG   = $clog2(N_POINTS / (2 * STAGE_SPAN));
    localparam logic [AW-1:0] SPAN_MASK = AW'(STAGE_SPAN - 1);
    localparam logic [AW-1:0] SPAN_OFS  = AW'(STAGE_SPAN);
    localparam logic [AW-1:0] LAST_IDX  = AW'(N_POINTS - 1);
    localparam logic [PW-1:0] LAST_PAIR = PW'(N_POINTS / 2 - 1);
    localparam logic [HW-1:0] LAST_HOLD = HW'(BF_LATENCY);

    typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_COMPUTE = 2'd1, ST_DRAIN = 2'd2} state_t;

    function automatic logic [AW-1:0] pair_m(input logic [PW-1:0] p);
        logic [AW-1:0] pe;
        pe = AW'(p);
        return ((pe >> SPAN_LG) << (SPAN_LG + 1)) | (pe & SPAN_MASK);
    endfunction

    function automatic logic [2:0] pair_tw(input logic [PW-1:0] p);
        logic [AW+2:0] je;
        je = (AW + 3)'(AW'(p) & SPAN_MASK) << TW_LG;
        return je[2:0];
    endfunction

    function automatic logic [DATA_W-1:0] wb_scale(input logic [DATA_W-1:0] x);
`ifdef FEEDER_SCALE_EN
        return {x[DATA_W-1], x[DATA_W-1:1]};
`else
        return x;
`endif
    endfunction

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [PW-1:0]     pair_cnt_q, pair_cnt_d, nxt_pair_s;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0] mem_re_q [N_POINTS];
    logic [DATA_W-1:0] mem_im_q [N_POINTS];
    logic [DATA_W-1:0] bfm_re_q, bfm_re_d, bfm_im_q, bfm_im_d;
    logic [DATA_W-1:0] bfn_re_q, bfn_re_d, bfn_im_q, bfn_im_d;
    logic [2:0]        bf_idx_q, bf_idx_d;
    logic [DATA_W-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
    logic              done_q, done_d;
    logic              ld_we_s, wb_we_s;
    logic [AW-1:0]     cur_m_s, cur_n_s, nxt_m_s, nxt_n_s;
    logic [DATA_W-1:0] wb_m_re_s, wb_m_im_s, wb_n_re_s, wb_n_im_s;

    // Pair addressing and write-back data shaping
    always_comb begin
        cur_m_s    = pair_m(pair_cnt_q);
        cur_n_s    = cur_m_s + SPAN_OFS;
        nxt_pair_s = (state_q == ST_COMPUTE) ? pair_cnt_q + PW'(1) : '0;
        nxt_m_s    = pair_m(nxt_pair_s);
        nxt_n_s    = nxt_m_s + SPAN_OFS;
        wb_m_re_s  = wb_scale(bf_x_m_1_real);
        wb_m_im_s  = wb_scale(bf_x_m_1_img);
        wb_n_re_s  = wb_scale(bf_x_n_1_real);
        wb_n_im_s  = wb_scale(bf_x_n_1_img);
    end

    // Next-state, counter and output-register logic
    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        pair_cnt_d = pair_cnt_q;
        hold_cnt_d = hold_cnt_q;
        bfm_re_d   = bfm_re_q;
        bfm_im_d   = bfm_im_q;
        bfn_re_d   = bfn_re_q;
        bfn_im_d   = bfn_im_q;
        bf_idx_d   = bf_idx_q;
        out_re_d   = out_re_q;
        out_im_d   = out_im_q;
        done_d     = 1'b0;
        ld_we_s    = 1'b0;
        wb_we_s    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    ld_we_s  = 1'b1;
                    wr_cnt_d = wr_cnt_q + AW'(1);
                    if (wr_cnt_q == LAST_IDX) begin
                        // Pair 0 never touches the sample being written this cycle
                        state_d    = ST_COMPUTE;
                        wr_cnt_d   = '0;
                        pair_cnt_d = '0;
                        hold_cnt_d = '0;
                        bfm_re_d   = mem_re_q[nxt_m_s];
                        bfm_im_d   = mem_im_q[nxt_m_s];
                        bfn_re_d   = mem_re_q[nxt_n_s];
                        bfn_im_d   = mem_im_q[nxt_n_s];
                        bf_idx_d   = pair_tw(nxt_pair_s);
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    wr_cnt_d = wr_cnt_q;
                end
            end
            ST_COMPUTE: begin
                if (hold_cnt_q == LAST_HOLD) begin
                    wb_we_s    = 1'b1;
                    hold_cnt_d = '0;
                    if (pair_cnt_q == LAST_PAIR) begin
                        state_d    = ST_DRAIN;
                        pair_cnt_d = '0;
                        bfm_re_d   = '0;
                        bfm_im_d   = '0;
                        bfn_re_d   = '0;
                        bfn_im_d   = '0;
                        bf_idx_d   = 3'd0;
                        // Forward sample 0 if the final write-back lands on it
                        out_re_d   = (cur_m_s == '0) ? wb_m_re_s :
                                     (cur_n_s == '0) ? wb_n_re_s : mem_re_q[0];
                        out_im_d   = (cur_m_s == '0) ? wb_m_im_s :
                                     (cur_n_s == '0) ? wb_n_im_s : mem_im_q[0];
                    end else begin
                        pair_cnt_d = nxt_pair_s;
                        bfm_re_d   = mem_re_q[nxt_m_s];
                        bfm_im_d   = mem_im_q[nxt_m_s];
                        bfn_re_d   = mem_re_q[nxt_n_s];
                        bfn_im_d   = mem_im_q[nxt_n_s];
                        bf_idx_d   = pair_tw(nxt_pair_s);
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d  = ST_LOAD;
                        rd_cnt_d = '0;
                        out_re_d = '0;
                        out_im_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + AW'(1);
                        out_re_d = mem_re_q[rd_cnt_q + AW'(1)];
                        out_im_d = mem_im_q[rd_cnt_q + AW'(1)];
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            pair_cnt_q <= '0;
            hold_cnt_q <= '0;
            bfm_re_q   <= '0;
            bfm_im_q   <= '0;
            bfn_re_q   <= '0;
            bfn_im_q   <= '0;
            bf_idx_q   <= 3'd0;
            out_re_q   <= '0;
            out_im_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            pair_cnt_q <= pair_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            bfm_re_q   <= bfm_re_d;
            bfm_im_q   <= bfm_im_d;
            bfn_re_q   <= bfn_re_d;
            bfn_im_q   <= bfn_im_d;
            bf_idx_q   <= bf_idx_d;
            out_re_q   <= out_re_d;
            out_im_q   <= out_im_d;
            done_q     <= done_d;
        end
    end

    // Frame buffer: one load write port, two in-place write-back ports
    always_ff @(posedge clk) begin
        if (ld_we_s) begin
            mem_re_q[wr_cnt_q] <= in_real;
            mem_im_q[wr_cnt_q] <= in_img;
        end else if (wb_we_s) begin
            mem_re_q[cur_m_s] <= wb_m_re_s;
            mem_im_q[cur_m_s] <= wb_m_im_s;
            mem_re_q[cur_n_s] <= wb_n_re_s;
            mem_im_q[cur_n_s] <= wb_n_im_s;
        end
    end

    assign in_ready    = (state_q == ST_LOAD);
    assign out_valid   = (state_q == ST_DRAIN);
    assign busy        = (state_q != ST_LOAD);
    assign frame_done  = done_q;
    assign out_real    = out_re_q;
    assign out_img     = out_im_q;
    assign bf_x_m_real = bfm_re_q;
    assign bf_x_m_img  = bfm_im_q;
    assign bf_x_n_real = bfn_re_q;
    assign bf_x_n_img  = bfn_im_q;
    assign bf_index    = bf_idx_q;
endmodule

// File: tb/tb_butterfly_stage_feeder_6.sv
// Bench for butterfly_stage_feeder_6 with a sum/difference butterfly stub; honours FEEDER_SCALE_EN.
module tb_butterfly_stage_feeder_6;
    logic clk = 1'b0;
    logic rst_n, in_valid, out_ready;
    logic in_ready, out_valid, frame_done, busy;
    logic signed [11:0] in_real, in_img, out_real, out_img;
    logic signed [11:0] bfm_re, bfm_im, bfn_re, bfn_im;
    logic signed [11:0] st_m_re, st_m_im, st_n_re, st_n_im;
    logic [2:0] bf_index;

    typedef struct {
        int pos;
        logic signed [11:0] a_re, a_im, b_re, b_im;
        logic signed [11:0] em_re, em_im, en_re, en_im;
        bit stall;
        bit hold_iv;
    } vec_t;

    vec_t tbl[3];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    butterfly_stage_feeder_6 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_img(in_img),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_img(out_img),
        .frame_done(frame_done), .busy(busy),
        .bf_x_m_real(bfm_re), .bf_x_m_img(bfm_im), .bf_x_n_real(bfn_re), .bf_x_n_img(bfn_im),
        .bf_index(bf_index),
        .bf_x_m_1_real(st_m_re), .bf_x_m_1_img(st_m_im),
        .bf_x_n_1_real(st_n_re), .bf_x_n_1_img(st_n_im)
    );

    always #5 clk = ~clk;

    // One-cycle butterfly stub: sum on the m path, difference on the n path
    always @(posedge clk) begin
        st_m_re <= bfm_re + bfn_re;
        st_m_im <= bfm_im + bfn_im;
        st_n_re <= bfm_re - bfn_re;
        st_n_im <= bfm_im - bfn_im;
    end

    always @(negedge clk) if (frame_done) done_cnt++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_frame(input vec_t v);
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_real  = (k == v.pos) ? v.a_re : (k == v.pos + 8) ? v.b_re : 12'sd0;
            in_img   = (k == v.pos) ? v.a_im : (k == v.pos + 8) ? v.b_im : 12'sd0;
            @(posedge clk);
            #1;
        end
        in_valid = v.hold_iv;
        in_real  = 12'sh555;
        in_img   = -12'sd7;
    endtask

    task automatic finish_frame(input vec_t v);
        logic signed [11:0] exr[16];
        logic signed [11:0] exi[16];
        logic [2:0] seq[32];
        logic signed [11:0] cm_re, cm_im, cn_re, cn_im;
        int ccnt, seq_bad, acc, viol, d0;
        for (int k = 0; k < 16; k++) begin
            exr[k] = 12'sd0;
            exi[k] = 12'sd0;
        end
        exr[v.pos] = v.em_re; exi[v.pos] = v.em_im;
        exr[v.pos + 8] = v.en_re; exi[v.pos + 8] = v.en_im;
        cm_re = 12'sh3C3; cm_im = 12'sh3C3; cn_re = 12'sh3C3; cn_im = 12'sh3C3;
        ccnt = 0; viol = 0; d0 = done_cnt;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) break;
            if (!busy || in_ready) viol++;
            if (ccnt < 32) seq[ccnt] = bf_index;
            if (ccnt == 2 * v.pos) begin
                cm_re = bfm_re; cm_im = bfm_im; cn_re = bfn_re; cn_im = bfn_im;
            end
            ccnt++;
        end
        chk("compute_cycles", ccnt, 16);
        seq_bad = 0;
        for (int c = 0; c < 16 && c < ccnt; c++) if (seq[c] != 3'(c / 2)) seq_bad++;
        chk("bf_index_seq", seq_bad, 0);
        chk("op_m_re", cm_re, v.a_re);
        chk("op_m_im", cm_im, v.a_im);
        chk("op_n_re", cn_re, v.b_re);
        chk("op_n_im", cn_im, v.b_im);
        acc = 0;
        for (int cyc = 0; cyc < 200 && acc < 16; cyc++) begin
            out_ready = v.stall ? (cyc % 3 == 0) : 1'b1;
            if (!out_valid || in_ready) viol++;
            chk($sformatf("out_re[%0d]", acc), out_real, exr[acc]);
            chk($sformatf("out_im[%0d]", acc), out_img, exi[acc]);
            if (out_ready) begin
                acc++;
                if (acc == 16) in_valid = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("accepts", acc, 16);
        chk("frame_done_cnt", done_cnt - d0, 1);
        chk("handshake_viol", viol, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int found;
`ifdef FEEDER_SCALE_EN
        tbl[0] = '{0, -12'sd101, 12'sd0, 12'sd1, 12'sd0, -12'sd50, 12'sd0, -12'sd51, 12'sd0, 1'b0, 1'b0};
        tbl[1] = '{3, -12'sd5, 12'sd7, 12'sd10, -12'sd3, 12'sd2, 12'sd2, -12'sd8, 12'sd5, 1'b1, 1'b0};
        tbl[2] = '{7, 12'sd2047, -12'sd2048, 12'sd1, 12'sd1, -12'sd1024, -12'sd1024, 12'sd1023, 12'sd1023, 1'b0, 1'b1};
`else
        tbl[0] = '{0, 12'sd100, 12'sd0, 12'sd20, 12'sd0, 12'sd120, 12'sd0, 12'sd80, 12'sd0, 1'b0, 1'b0};
        tbl[1] = '{3, -12'sd5, 12'sd7, 12'sd10, -12'sd3, 12'sd5, 12'sd4, -12'sd15, 12'sd10, 1'b1, 1'b0};
        tbl[2] = '{7, 12'sd2047, -12'sd2048, 12'sd1, 12'sd1, -12'sd2048, -12'sd2047, 12'sd2046, 12'sd2047, 1'b0, 1'b1};
`endif
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_real = 12'sd0; in_img = 12'sd0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_bf_index", bf_index, 0);
        chk("rst_bf_m_re", bfm_re, 0);
        chk("rst_out_re", out_real, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            load_frame(tbl[i]);
            finish_frame(tbl[i]);
        end

        // Reset while pair 4 is in flight, then a fresh frame
        load_frame(tbl[0]);
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bf_index == 3'd4) begin
                found = 1;
                break;
            end
        end
        chk("mid_reach_pair4", found, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_bf_index", bf_index, 0);
        chk("mid_rst_bf_m_re", bfm_re, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        load_frame(tbl[1]);
        finish_frame(tbl[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
